// File: rtl/scr1_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : scr1_imem_responder
//  Purpose  : Instruction-memory slave for the SCR1 IMEM bus. Serves
//             word-aligned reads from a single SRAM window, with optional
//             extra read latency, and answers anything else with RDY_ER.
//  Revision : 1.0 - initial release
// ============================================================================
module scr1_imem_responder #(
    parameter logic [31:0] MEM_BASE      = 32'h0048_0000,
    parameter int          MEM_SIZE_LOG2 = 16,
    parameter int          WAIT_CYCLES   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req_ack,
    input  logic                       imem_req,
    input  logic                       imem_cmd,
    input  logic [31:0]                imem_addr,
    output logic [31:0]                imem_rdata,
    output logic [1:0]                 imem_resp,
    output logic                       mem_en,
    output logic [MEM_SIZE_LOG2-3:0]   mem_addr,
    input  logic [31:0]                mem_rdata
);

    // SCR1 bus encodings (type_scr1_mem_cmd_e / type_scr1_mem_resp_e)
    localparam logic       c_CMD_RD      = 1'b0;
    localparam logic [1:0] c_RESP_NOTRDY = 2'b00;
    localparam logic [1:0] c_RESP_RDY_OK = 2'b01;
    localparam logic [1:0] c_RESP_RDY_ER = 2'b10;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [3:0] c_WAIT     = 4'(WAIT_CYCLES);
    localparam logic       c_HAS_WAIT = (WAIT_CYCLES != 0);

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [3:0]  r_cnt;
    logic        r_err;
    logic        r_cap;
    logic [31:0] r_data;
    logic        w_accept;
    logic        w_valid;
    logic [31:0] w_rdata_src;

    // Only one request may be outstanding, so WAIT is the sole busy state.
    assign imem_req_ack = (r_state != c_ST_WAIT);
    assign w_accept     = imem_req & imem_req_ack;

    assign w_valid = (imem_cmd == c_CMD_RD) &&
                     (imem_addr[1:0] == 2'b00) &&
                     (imem_addr[31:MEM_SIZE_LOG2] == MEM_BASE[31:MEM_SIZE_LOG2]);

    // SRAM strobe is issued in the accept cycle itself; it is gated by
    // rst_n so nothing reaches the SRAM while the block is held in reset.
    assign mem_en   = rst_n & w_accept & w_valid;
    assign mem_addr = imem_addr[MEM_SIZE_LOG2-1:2];

    // With no extra latency the SRAM output lines up with the response
    // cycle, so it is forwarded directly; otherwise the captured copy is used.
    assign w_rdata_src = c_HAS_WAIT ? r_data : mem_rdata;

    // Next-state selection; RESP accepts a new request exactly like IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_RESP: begin
                if (w_accept) begin
                    w_next = (w_valid && c_HAS_WAIT) ? c_ST_WAIT : c_ST_RESP;
                end else begin
                    w_next = c_ST_IDLE;
                end
            end
            c_ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next = c_ST_RESP;
                end
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    // State, wait counter and per-request error/data bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
            r_cap   <= 1'b0;
            r_data  <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cap   <= mem_en;
            if (r_cap) begin
                r_data <= mem_rdata;
            end
            if (w_accept) begin
                r_err <= !w_valid;
                r_cnt <= w_valid ? c_WAIT : 4'd0;
                if (!w_valid) begin
                    r_data <= 32'd0;
                end
            end else if (r_state == c_ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Response is driven only in RESP; the bus is quiet (NOTRDY, 0) otherwise.
    always_comb begin
        imem_resp  = c_RESP_NOTRDY;
        imem_rdata = 32'd0;
        if (r_state == c_ST_RESP) begin
            if (r_err) begin
                imem_resp = c_RESP_RDY_ER;
            end else begin
                imem_resp  = c_RESP_RDY_OK;
                imem_rdata = w_rdata_src;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/scr1_imem_responder.md
SCR1_IMEM_RESPONDER -- requirements
Module: scr1_imem_responder

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h0048_0000; byte base address of the served window, aligned to 2**MEM_SIZE_LOG2.
REQ-002 SHALL have parameter MEM_SIZE_LOG2, default 16; window size in bytes is 2**MEM_SIZE_LOG2 (64 KiB).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, legal range 0..15; extra response latency for successful reads.
REQ-004 Ports (clock and reset first): clk in 1, clock; rst_n in 1, reset, asynchronous, active-low.
REQ-005 imem_req_ack out 1 (request accepted); imem_req in 1 (request valid); imem_cmd in type_scr1_mem_cmd_e (command); imem_addr in 32 (byte address).
REQ-006 imem_rdata out 32 (read data); imem_resp out type_scr1_mem_resp_e (NOTRDY / RDY_OK / RDY_ER).
REQ-007 mem_en out 1 (SRAM read strobe); mem_addr out MEM_SIZE_LOG2-2 (word index); mem_rdata in 32 (SRAM data, valid exactly 1 cycle after mem_en).

Function
REQ-008 A request SHALL be accepted in cycle T iff imem_req & imem_req_ack are both high in T.
REQ-009 imem_req_ack SHALL be high in state IDLE and in state RESP, and low in state WAIT.
REQ-010 An accepted request SHALL be valid iff imem_cmd==SCR1_MEM_CMD_RD, imem_addr[1:0]==0, and imem_addr[31:MEM_SIZE_LOG2]==MEM_BASE[31:MEM_SIZE_LOG2].
REQ-011 A valid accept in T SHALL drive mem_en=1 and mem_addr=imem_addr[MEM_SIZE_LOG2-1:2] combinationally in T. mem_en SHALL be 0 in every other cycle, including invalid accepts.
REQ-012 A valid read SHALL capture mem_rdata into an internal data register at T+1.
REQ-013 A valid read SHALL produce imem_resp=RDY_OK for exactly one cycle, at T+1+WAIT_CYCLES.
REQ-014 When WAIT_CYCLES==0, imem_rdata in the response cycle SHALL equal mem_rdata. Otherwise it SHALL equal the captured register.
REQ-015 An invalid request SHALL produce imem_resp=RDY_ER with imem_rdata=0 for exactly one cycle, at T+1, independent of WAIT_CYCLES.
REQ-016 Outside the response cycle, imem_resp SHALL be NOTRDY and imem_rdata SHALL be 0.
REQ-017 FSM states and transitions:
- IDLE: on valid accept, go to WAIT if WAIT_CYCLES>0, else RESP; on invalid accept, go to RESP (error flag set); otherwise stay.
- WAIT: 4-bit counter loaded with WAIT_CYCLES at accept; decrement each cycle; go to RESP when the counter reaches 1.
- RESP: drive the response; on accept in the same cycle, branch exactly as from IDLE; otherwise go to IDLE.
REQ-018 Back-to-back requests SHALL be supported: an accept in the RESP cycle SHALL NOT drop or delay either the current response or the new request.
REQ-019 At most one request SHALL be outstanding; no request SHALL be accepted in WAIT, even if imem_req is held high.
REQ-020 The error flag and captured data SHALL be per-request. A new accept in RESP SHALL overwrite both with no leakage into the next response.
REQ-021 imem_req falling while in WAIT SHALL NOT affect the pending response.
REQ-022 Address window check SHALL use full 32-bit compare, so 0xFFFF_FFFC and MEM_BASE-4 SHALL yield RDY_ER.

Reset
REQ-023 rst_n low SHALL asynchronously force: state IDLE, counter 0, error flag 0, captured data 0.
REQ-024 While rst_n is low, outputs SHALL be: imem_resp NOTRDY, imem_rdata 0, mem_en 0; imem_req_ack follows the IDLE rule (1).
REQ-025 Reset asserted mid-transaction (WAIT or RESP) SHALL abort it with no response emitted after reset release.
REQ-026 After reset release, the first accept SHALL be possible in the first rising clk edge.

Verification
REQ-027 WAIT_CYCLES=0: RD at 0x0048_0010 with SRAM word[4]=0xDEADBEEF, accepted at T -> mem_en=1, mem_addr=4 at T; RDY_OK and rdata 0xDEADBEEF at T+1.
REQ-028 WAIT_CYCLES=3: RD at 0x0048_0000, imem_req held high throughout -> req_ack low at T+1..T+3; RDY_OK at T+4 with captured data; second request accepted at T+4.
REQ-029 Errors: WR cmd; addr 0x0048_0002; addr 0x0049_0000 -> each gives RDY_ER with rdata 0 at T+1 and mem_en never asserted.
REQ-030 WAIT_CYCLES=0, continuous RD stream to words 0,1,2 -> one RDY_OK per cycle with matching data, followed by an error request in the stream -> RDY_ER in the following cycle with no stale data.
REQ-031 WAIT_CYCLES=5: rst_n pulsed low in the second WAIT cycle -> no RDY_OK ever emitted; req_ack=1 and resp NOTRDY immediately after release.
